// File: rtl/counter_checker.sv
// Passive checker for a free-running binary up-counter. It locks after LOCK_COUNT
// consecutive +1 steps, then pulses error on each miss and records the first failure.
module counter_checker #(
  parameter int WIDTH      = 8,
  parameter int LOCK_COUNT = 4,
  parameter int ERR_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] value,
  input  logic             ctr_rst,
  input  logic             clr,
  output logic             locked,
  output logic             error,
  output logic [ERR_W-1:0] err_count,
  output logic             first_valid,
  output logic [WIDTH-1:0] first_got,
  output logic [WIDTH-1:0] first_exp
);

  localparam int RUN_W = $clog2(LOCK_COUNT + 1);

  typedef enum logic [1:0] {S_EMPTY, S_ACQ, S_LOCKED} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   prev_q, prev_d;
  logic [RUN_W-1:0]   run_q, run_d;
  logic               error_q, error_d;
  logic [ERR_W-1:0]   cnt_q, cnt_d;
  logic               fv_q, fv_d;
  logic [WIDTH-1:0]   fg_q, fg_d;
  logic [WIDTH-1:0]   fe_q, fe_d;

  logic [WIDTH-1:0]   exp_val;
  logic [RUN_W-1:0]   run_inc;
  logic               match;

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  assign exp_val = prev_q + 1'b1;
  assign run_inc = run_q + 1'b1;
  assign match   = (value == exp_val);

  always_comb begin
    state_d = state_q;
    prev_d  = prev_q;
    run_d   = run_q;
    error_d = 1'b0;
    cnt_d   = cnt_q;
    fv_d    = fv_q;
    fg_d    = fg_q;
    fe_d    = fe_q;

    if (en) begin
      // Every sample becomes the new reference, including ctr_rst samples.
      prev_d = value;
      if (!ctr_rst) begin
        unique case (state_q)
          S_EMPTY: begin
            state_d = S_ACQ;
            run_d   = '0;
          end
          S_ACQ: begin
            if (!match) begin
              run_d = '0;
            end else if (run_inc == RUN_W'(LOCK_COUNT)) begin
              state_d = S_LOCKED;
              run_d   = '0;
            end else begin
              run_d = run_inc;
            end
          end
          S_LOCKED: begin
            if (!match) begin
              error_d = 1'b1;
              cnt_d   = sat_inc(cnt_q);
              state_d = S_ACQ;
              run_d   = '0;
              if (!fv_q) begin
                fv_d = 1'b1;
                fg_d = value;
                fe_d = exp_val;
              end
            end
          end
          default: begin
            state_d = S_EMPTY;
            run_d   = '0;
          end
        endcase
      end
    end

    // Clear overrides any same-edge capture but leaves error/state alone.
    if (clr) begin
      cnt_d = '0;
      fv_d  = 1'b0;
      fg_d  = '0;
      fe_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_EMPTY;
      prev_q  <= '0;
      run_q   <= '0;
      error_q <= 1'b0;
      cnt_q   <= '0;
      fv_q    <= 1'b0;
      fg_q    <= '0;
      fe_q    <= '0;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
      run_q   <= run_d;
      error_q <= error_d;
      cnt_q   <= cnt_d;
      fv_q    <= fv_d;
      fg_q    <= fg_d;
      fe_q    <= fe_d;
    end
  end

  assign locked      = (state_q == S_LOCKED);
  assign error       = error_q;
  assign err_count   = cnt_q;
  assign first_valid = fv_q;
  assign first_got   = fg_q;
  assign first_exp   = fe_q;

endmodule

// File: tb/tb_counter_checker.sv
// Bench for counter_checker: directed scenarios plus a randomized stream, all
// checked against a behavioural model of the counter-checking rules.
module tb_counter_checker;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [7:0]  value;
  logic        ctr_rst;
  logic        clr;

  logic        locked, error, first_valid;
  logic [15:0] err_count;
  logic [7:0]  first_got, first_exp;

  logic        s_locked, s_error, s_first_valid;
  logic [1:0]  s_err_count;
  logic [7:0]  s_first_got, s_first_exp;

  int checks = 0;
  int errors = 0;

  // Behavioural model: whether anything was sampled, lock flag, good-step run.
  bit m_started, m_locked, m_err, m_fv;
  int m_run, m_prev, m_c16, m_c2, m_fg, m_fe;

  counter_checker #(.WIDTH(8), .LOCK_COUNT(4), .ERR_W(16)) u_dut (
    .clk(clk), .reset(reset), .en(en), .value(value), .ctr_rst(ctr_rst), .clr(clr),
    .locked(locked), .error(error), .err_count(err_count),
    .first_valid(first_valid), .first_got(first_got), .first_exp(first_exp)
  );

  counter_checker #(.WIDTH(8), .LOCK_COUNT(4), .ERR_W(2)) u_sat (
    .clk(clk), .reset(reset), .en(en), .value(value), .ctr_rst(ctr_rst), .clr(clr),
    .locked(s_locked), .error(s_error), .err_count(s_err_count),
    .first_valid(s_first_valid), .first_got(s_first_got), .first_exp(s_first_exp)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_started = 0; m_locked = 0; m_err = 0; m_fv = 0;
    m_run = 0; m_prev = 0; m_c16 = 0; m_c2 = 0; m_fg = 0; m_fe = 0;
  endtask

  task automatic model_step(input bit e, input int v, input bit cr, input bit c);
    int expv;
    m_err = 0;
    if (e && !cr) begin
      expv = (m_prev + 1) % 256;
      if (!m_started) begin
        m_started = 1;
        m_run = 0;
      end else if (v == expv) begin
        if (!m_locked) begin
          m_run = m_run + 1;
          if (m_run >= 4) m_locked = 1;
        end
      end else begin
        if (m_locked) begin
          m_err = 1;
          m_c16 = (m_c16 < 65535) ? m_c16 + 1 : 65535;
          m_c2  = (m_c2 < 3) ? m_c2 + 1 : 3;
          if (!m_fv) begin
            m_fv = 1; m_fg = v; m_fe = expv;
          end
          m_locked = 0;
        end
        m_run = 0;
      end
    end
    if (e) m_prev = v;
    if (c) begin
      m_c16 = 0; m_c2 = 0; m_fv = 0; m_fg = 0; m_fe = 0;
    end
  endtask

  task automatic drive(input bit e, input int v, input bit cr, input bit c);
    en = e; value = v[7:0]; ctr_rst = cr; clr = c;
    @(posedge clk);
    model_step(e, v % 256, cr, c);
    #1;
  endtask

  task automatic test_reset();
    #3;
    checks += 8;
    if (locked !== 1'b0)      begin errors++; $display("FAIL rst_locked got %0b exp 0", locked); end
    if (error !== 1'b0)       begin errors++; $display("FAIL rst_error got %0b exp 0", error); end
    if (err_count !== 16'd0)  begin errors++; $display("FAIL rst_err_count got %0d exp 0", err_count); end
    if (first_valid !== 1'b0) begin errors++; $display("FAIL rst_first_valid got %0b exp 0", first_valid); end
    if (first_got !== 8'd0)   begin errors++; $display("FAIL rst_first_got got %0h exp 0", first_got); end
    if (first_exp !== 8'd0)   begin errors++; $display("FAIL rst_first_exp got %0h exp 0", first_exp); end
    if (s_err_count !== 2'd0) begin errors++; $display("FAIL rst_sat_count got %0d exp 0", s_err_count); end
    if (s_locked !== 1'b0)    begin errors++; $display("FAIL rst_sat_locked got %0b exp 0", s_locked); end
    #9 reset = 1'b1;
  endtask

  task automatic test_clean_wrap();
    for (int k = 1; k <= 261; k++) begin
      drive(1, (k - 1) % 256, 0, 0);
      checks += 3;
      if (locked !== m_locked) begin errors++; $display("FAIL wrap_locked k=%0d got %0b exp %0b", k, locked, m_locked); end
      if (locked !== (k >= 5)) begin errors++; $display("FAIL wrap_lock_time k=%0d got %0b exp %0b", k, locked, (k >= 5)); end
      if (err_count !== 16'd0 || error !== 1'b0) begin
        errors++; $display("FAIL wrap_no_error k=%0d got cnt %0d err %0b exp 0 0", k, err_count, error);
      end
    end
  endtask

  task automatic test_mismatch();
    while (m_prev != 8'h0B) drive(1, m_prev + 1, 0, 0);
    drive(1, 8'h10, 0, 0);
    checks += 7;
    if (error !== 1'b1)         begin errors++; $display("FAIL mm_error got %0b exp 1", error); end
    if (err_count !== 16'd1)    begin errors++; $display("FAIL mm_count got %0d exp 1", err_count); end
    if (first_valid !== 1'b1)   begin errors++; $display("FAIL mm_first_valid got %0b exp 1", first_valid); end
    if (first_got !== 8'h10)    begin errors++; $display("FAIL mm_first_got got %0h exp 10", first_got); end
    if (first_exp !== 8'h0C)    begin errors++; $display("FAIL mm_first_exp got %0h exp 0c", first_exp); end
    if (locked !== 1'b0)        begin errors++; $display("FAIL mm_unlock got %0b exp 0", locked); end
    if (s_err_count !== 2'd1)   begin errors++; $display("FAIL mm_sat_count got %0d exp 1", s_err_count); end
    drive(1, 8'h11, 0, 0);
    checks++;
    if (error !== 1'b0) begin errors++; $display("FAIL mm_single_pulse got %0b exp 0", error); end
    drive(1, 8'h12, 0, 0);
    drive(1, 8'h13, 0, 0);
    checks++;
    if (locked !== 1'b0) begin errors++; $display("FAIL mm_early_relock got %0b exp 0", locked); end
    drive(1, 8'h14, 0, 0);
    checks += 2;
    if (locked !== 1'b1) begin errors++; $display("FAIL mm_relock got %0b exp 1", locked); end
    if (locked !== m_locked) begin errors++; $display("FAIL mm_model_lock got %0b exp %0b", locked, m_locked); end
  endtask

  task automatic test_ctr_rst();
    drive(1, 8'h15, 0, 0);
    drive(1, 8'h16, 0, 0);
    drive(1, 8'h00, 1, 0);
    checks += 2;
    if (error !== 1'b0)  begin errors++; $display("FAIL cr_hold_error got %0b exp 0", error); end
    if (locked !== 1'b1) begin errors++; $display("FAIL cr_hold_locked got %0b exp 1", locked); end
    drive(1, 8'h01, 0, 0);
    drive(1, 8'h02, 0, 0);
    checks += 3;
    if (error !== 1'b0)      begin errors++; $display("FAIL cr_next_error got %0b exp 0", error); end
    if (locked !== 1'b1)     begin errors++; $display("FAIL cr_next_locked got %0b exp 1", locked); end
    if (err_count !== 16'd1) begin errors++; $display("FAIL cr_count got %0d exp 1", err_count); end
  endtask

  task automatic test_en_toggle();
    for (int i = 0; i < 40; i++) begin
      if (i % 2 == 0) drive(1, m_prev + 1, 0, 0);
      else            drive(0, $urandom_range(0, 255), 0, 0);
      checks += 3;
      if (error !== 1'b0) begin errors++; $display("FAIL en_error i=%0d got %0b exp 0", i, error); end
      if (locked !== m_locked) begin errors++; $display("FAIL en_locked i=%0d got %0b exp %0b", i, locked, m_locked); end
      if (err_count !== m_c16[15:0]) begin errors++; $display("FAIL en_count i=%0d got %0d exp %0d", i, err_count, m_c16); end
    end
  endtask

  task automatic test_clr();
    int pulses = 0;
    for (int n = 0; n < 3; n++) begin
      drive(1, m_prev + 5, 0, (n == 2));
      if (error) pulses++;
      if (n < 2) begin
        for (int g = 0; g < 4; g++) begin
          drive(1, m_prev + 1, 0, 0);
          if (error) pulses++;
        end
      end
    end
    checks += 6;
    if (pulses != 3)           begin errors++; $display("FAIL clr_pulses got %0d exp 3", pulses); end
    if (err_count !== 16'd0)   begin errors++; $display("FAIL clr_count got %0d exp 0", err_count); end
    if (first_valid !== 1'b0)  begin errors++; $display("FAIL clr_first_valid got %0b exp 0", first_valid); end
    if (first_got !== 8'd0)    begin errors++; $display("FAIL clr_first_got got %0h exp 0", first_got); end
    if (locked !== 1'b0)       begin errors++; $display("FAIL clr_state got %0b exp 0", locked); end
    if (s_err_count !== 2'd0)  begin errors++; $display("FAIL clr_sat_count got %0d exp 0", s_err_count); end
  endtask

  task automatic test_saturate();
    for (int n = 0; n < 5; n++) begin
      for (int g = 0; g < 4; g++) drive(1, m_prev + 1, 0, 0);
      drive(1, m_prev + 7, 0, 0);
    end
    checks += 3;
    if (s_err_count !== 2'd3) begin errors++; $display("FAIL sat_count got %0d exp 3", s_err_count); end
    if (err_count !== 16'd5)  begin errors++; $display("FAIL sat_wide_count got %0d exp 5", err_count); end
    if (s_err_count !== m_c2[1:0]) begin errors++; $display("FAIL sat_model got %0d exp %0d", s_err_count, m_c2); end
    drive(1, m_prev + 1, 0, 0);
    reset = 1'b0;
    #2;
    checks += 6;
    if (locked !== 1'b0 || s_locked !== 1'b0) begin errors++; $display("FAIL arst_locked got %0b %0b exp 0", locked, s_locked); end
    if (error !== 1'b0 || s_error !== 1'b0)   begin errors++; $display("FAIL arst_error got %0b %0b exp 0", error, s_error); end
    if (err_count !== 16'd0)  begin errors++; $display("FAIL arst_count got %0d exp 0", err_count); end
    if (s_err_count !== 2'd0) begin errors++; $display("FAIL arst_sat_count got %0d exp 0", s_err_count); end
    if (first_valid !== 1'b0 || s_first_valid !== 1'b0) begin errors++; $display("FAIL arst_first_valid got %0b exp 0", first_valid); end
    if (first_got !== 8'd0 || first_exp !== 8'd0) begin errors++; $display("FAIL arst_first got %0h/%0h exp 0/0", first_got, first_exp); end
    model_reset();
    #2 reset = 1'b1;
  endtask

  task automatic test_random();
    bit e, cr, c;
    int v, r;
    for (int i = 0; i < 400; i++) begin
      e  = ($urandom_range(0, 3) != 0);
      r  = $urandom_range(0, 19);
      cr = (r == 1);
      c  = ($urandom_range(0, 29) == 0);
      if (r == 0)      v = $urandom_range(0, 255);
      else if (cr)     v = 0;
      else             v = (m_prev + 1) % 256;
      drive(e, v, cr, c);
      checks += 8;
      if (locked !== m_locked) begin errors++; $display("FAIL rnd_locked i=%0d got %0b exp %0b", i, locked, m_locked); end
      if (error !== m_err)     begin errors++; $display("FAIL rnd_error i=%0d got %0b exp %0b", i, error, m_err); end
      if (err_count !== m_c16[15:0]) begin errors++; $display("FAIL rnd_count i=%0d got %0d exp %0d", i, err_count, m_c16); end
      if (s_err_count !== m_c2[1:0]) begin errors++; $display("FAIL rnd_sat_count i=%0d got %0d exp %0d", i, s_err_count, m_c2); end
      if (first_valid !== m_fv) begin errors++; $display("FAIL rnd_first_valid i=%0d got %0b exp %0b", i, first_valid, m_fv); end
      if (first_got !== m_fg[7:0]) begin errors++; $display("FAIL rnd_first_got i=%0d got %0h exp %0h", i, first_got, m_fg); end
      if (first_exp !== m_fe[7:0]) begin errors++; $display("FAIL rnd_first_exp i=%0d got %0h exp %0h", i, first_exp, m_fe); end
      if (s_locked !== m_locked) begin errors++; $display("FAIL rnd_sat_locked i=%0d got %0b exp %0b", i, s_locked, m_locked); end
    end
  endtask

  initial begin
    reset = 1'b0; en = 1'b0; value = 8'd0; ctr_rst = 1'b0; clr = 1'b0;
    model_reset();
    test_reset();
    test_clean_wrap();
    test_mismatch();
    test_ctr_rst();
    test_en_toggle();
    test_clr();
    test_saturate();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
